// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter: owner codes, FSM states,
// grant vector bit positions and the access-latency counter width.
package mem_port_arbiter_pkg;

   localparam int unsigned CNT_W = 4;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_IF   = 2'b01;
   localparam logic [1:0] OWN_DM   = 2'b10;
   localparam logic [1:0] OWN_LD   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_ACK
   } state_e;

   // Bit positions inside the one-hot grant vector.
   localparam int unsigned GNT_IF = 0;
   localparam int unsigned GNT_DM = 1;
   localparam int unsigned GNT_LD = 2;

endpackage

// File: rtl/mpa_rr_pick.sv
// Combinational picker: loader always wins; if/dm resolved by round-robin
// pointer (0 favours if) or by fixed dm priority when round-robin is off.
module mpa_rr_pick
   import mem_port_arbiter_pkg::*;
(
   input  logic       ld_req,
   input  logic       if_req,
   input  logic       dm_req,
   input  logic       rr_ptr,
   input  logic       rr_en,
   output logic [2:0] grant
);

   always_comb begin
      grant = 3'b000;
      if (ld_req) begin
         grant[GNT_LD] = 1'b1;
      end else if (if_req && dm_req) begin
         if (rr_en && !rr_ptr) begin
            grant[GNT_IF] = 1'b1;
         end else begin
            grant[GNT_DM] = 1'b1;
         end
      end else if (if_req) begin
         grant[GNT_IF] = 1'b1;
      end else if (dm_req) begin
         grant[GNT_DM] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between fetch, data and loader
// requesters with an IDLE -> ACCESS -> ACK sequence; all outputs registered.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned LATENCY = 2,
   parameter bit          RR_EN   = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ld_req,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   output logic          ld_ack,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_ack,
   output logic [DW-1:0] dm_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic [1:0]    owner
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             rr_ptr_q;
   logic [2:0]       grant;

   mpa_rr_pick u_pick (
      .ld_req (ld_req),
      .if_req (if_req),
      .dm_req (dm_req),
      .rr_ptr (rr_ptr_q),
      .rr_en  (RR_EN),
      .grant  (grant)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         rr_ptr_q  <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_ack    <= 1'b0;
         dm_ack    <= 1'b0;
         ld_ack    <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         busy      <= 1'b0;
         owner     <= OWN_NONE;
      end else begin
         if_ack <= 1'b0;
         dm_ack <= 1'b0;
         ld_ack <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (grant != 3'b000) begin
                  mem_en  <= 1'b1;
                  busy    <= 1'b1;
                  cnt_q   <= CNT_INIT;
                  state_q <= ST_ACCESS;
                  if (grant[GNT_LD]) begin
                     owner     <= OWN_LD;
                     mem_we    <= 1'b1;
                     mem_addr  <= ld_addr;
                     mem_wdata <= ld_wdata;
                  end else if (grant[GNT_DM]) begin
                     owner     <= OWN_DM;
                     mem_we    <= dm_we;
                     mem_addr  <= dm_addr;
                     mem_wdata <= dm_wdata;
                  end else begin
                     owner     <= OWN_IF;
                     mem_we    <= 1'b0;
                     mem_addr  <= if_addr;
                     mem_wdata <= '0;
                  end
               end
            end
            ST_ACCESS: begin
               // mem_rdata is only valid in the last access cycle.
               if (cnt_q == '0) begin
                  mem_en  <= 1'b0;
                  mem_we  <= 1'b0;
                  state_q <= ST_ACK;
                  if (owner == OWN_IF) begin
                     if_rdata <= mem_rdata;
                     if_ack   <= 1'b1;
                  end else if (owner == OWN_DM) begin
                     if (!mem_we) begin
                        dm_rdata <= mem_rdata;
                     end
                     dm_ack <= 1'b1;
                  end else begin
                     ld_ack <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_ACK: begin
               owner   <= OWN_NONE;
               busy    <= 1'b0;
               state_q <= ST_IDLE;
               if (owner == OWN_IF) begin
                  rr_ptr_q <= 1'b1;
               end else if (owner == OWN_DM) begin
                  rr_ptr_q <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: scoreboard of expected grants popped at each new memory access,
// plus LATENCY=1 (fixed priority) and LATENCY=15 instances for latency corners.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int unsigned L = 2;

   typedef struct packed {
      logic [1:0]  own;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } txn_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   // main instance
   logic        ld_req, ld_ack, if_req, if_ack, dm_req, dm_we, dm_ack;
   logic [31:0] ld_addr, ld_wdata, if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
   logic        mem_en, mem_we, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  owner;

   // LATENCY=1, fixed priority instance
   logic        l1_if_req, l1_if_ack, l1_dm_req, l1_dm_we, l1_dm_ack, l1_ld_ack;
   logic [31:0] l1_if_addr, l1_if_rdata, l1_dm_addr, l1_dm_rdata;
   logic        l1_mem_en, l1_mem_we, l1_busy;
   logic [31:0] l1_mem_addr, l1_mem_wdata;
   logic [1:0]  l1_owner;

   // LATENCY=15 instance
   logic        l15_if_req, l15_if_ack, l15_dm_ack, l15_ld_ack;
   logic [31:0] l15_if_addr, l15_if_rdata, l15_dm_rdata;
   logic        l15_mem_en, l15_mem_we, l15_busy;
   logic [31:0] l15_mem_addr, l15_mem_wdata;
   logic [1:0]  l15_owner;

   logic [31:0] mem_m [0:255];
   logic [31:0] ref_m [0:255];
   txn_t        exp_q [$];
   txn_t        cur;
   logic        cur_vld = 1'b0;
   logic        prev_en = 1'b0;
   logic [5:0]  ack_vec = 6'b0;
   int total = 0, bad = 0, cyc = 0, grant_cyc = 0, en_cycles = 0, last_en_len = 0;
   int n_if_ack = 0, n_dm_ack = 0, n_ld_ack = 0, n_l1_if = 0, n_l15_if = 0;

   assign mem_rdata = (mem_en && !mem_we && en_cycles == L) ? mem_m[mem_addr[9:2]]
                                                            : 32'hBAD0_BAD0;

   mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(L), .RR_EN(1'b1)) u_dut (
      .clk(clk), .reset(reset),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
   );

   mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(1), .RR_EN(1'b0)) u_l1 (
      .clk(clk), .reset(reset),
      .ld_req(1'b0), .ld_addr(32'h0), .ld_wdata(32'h0), .ld_ack(l1_ld_ack),
      .if_req(l1_if_req), .if_addr(l1_if_addr), .if_ack(l1_if_ack), .if_rdata(l1_if_rdata),
      .dm_req(l1_dm_req), .dm_we(l1_dm_we), .dm_addr(l1_dm_addr), .dm_wdata(32'h0),
      .dm_ack(l1_dm_ack), .dm_rdata(l1_dm_rdata),
      .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
      .mem_wdata(l1_mem_wdata), .mem_rdata(~l1_mem_addr), .busy(l1_busy), .owner(l1_owner)
   );

   mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(15), .RR_EN(1'b1)) u_l15 (
      .clk(clk), .reset(reset),
      .ld_req(1'b0), .ld_addr(32'h0), .ld_wdata(32'h0), .ld_ack(l15_ld_ack),
      .if_req(l15_if_req), .if_addr(l15_if_addr), .if_ack(l15_if_ack),
      .if_rdata(l15_if_rdata),
      .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
      .dm_ack(l15_dm_ack), .dm_rdata(l15_dm_rdata),
      .mem_en(l15_mem_en), .mem_we(l15_mem_we), .mem_addr(l15_mem_addr),
      .mem_wdata(l15_mem_wdata), .mem_rdata(~l15_mem_addr), .busy(l15_busy),
      .owner(l15_owner)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_if(input logic [31:0] a);
      txn_t t;
      t.own = OWN_IF; t.we = 1'b0; t.addr = a; t.wdata = 32'h0; t.rdata = ref_m[a[9:2]];
      exp_q.push_back(t);
   endtask

   task automatic push_dm(input logic we, input logic [31:0] a, input logic [31:0] d);
      txn_t t;
      if (we) ref_m[a[9:2]] = d;
      t.own = OWN_DM; t.we = we; t.addr = a; t.wdata = we ? d : 32'h0;
      t.rdata = ref_m[a[9:2]];
      exp_q.push_back(t);
   endtask

   task automatic push_ld(input logic [31:0] a, input logic [31:0] d);
      txn_t t;
      ref_m[a[9:2]] = d;
      t.own = OWN_LD; t.we = 1'b1; t.addr = a; t.wdata = d; t.rdata = 32'h0;
      exp_q.push_back(t);
   endtask

   // Per-cycle observer of the main instance; also plays the memory macro.
   task automatic mon();
      logic [2:0] exp_ack;
      cyc++;
      if (reset) begin
         cur_vld = 1'b0;
         en_cycles = 0;
      end else begin
         if (mem_en) begin
            en_cycles++;
            if (!prev_en) begin
               grant_cyc = cyc;
               check("grant_pending", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0) begin
                  cur = exp_q.pop_front();
                  cur_vld = 1'b1;
               end
               check("grant_ctl", 64'({owner, mem_we, busy}), 64'({cur.own, cur.we, 1'b1}));
               check("grant_addr", 64'(mem_addr), 64'(cur.addr));
               check("grant_wdata", 64'(mem_we ? mem_wdata : 32'h0), 64'(cur.wdata));
            end
            check("hold", 64'({mem_we, mem_addr}), 64'({cur.we, cur.addr}));
            if (mem_we && en_cycles == L) mem_m[mem_addr[9:2]] = mem_wdata;
         end else begin
            check("we_idle", 64'(mem_we), 64'd0);
            if (prev_en) last_en_len = en_cycles;
            en_cycles = 0;
         end
         if (if_ack || dm_ack || ld_ack) begin
            exp_ack = (cur.own == OWN_IF) ? 3'b100 : (cur.own == OWN_DM) ? 3'b010 : 3'b001;
            check("ack_cur", 64'(cur_vld), 64'd1);
            check("ack_vec", 64'({if_ack, dm_ack, ld_ack}), 64'(exp_ack));
            check("ack_lat", 64'(cyc - grant_cyc), 64'(L));
            check("en_len", 64'(last_en_len), 64'(L));
            if (cur.own == OWN_IF) check("if_rdata", 64'(if_rdata), 64'(cur.rdata));
            if (cur.own == OWN_DM && !cur.we) check("dm_rdata", 64'(dm_rdata), 64'(cur.rdata));
            cur_vld = 1'b0;
         end
      end
      n_if_ack += int'(if_ack);
      n_dm_ack += int'(dm_ack);
      n_ld_ack += int'(ld_ack);
      n_l1_if  += int'(l1_if_ack);
      n_l15_if += int'(l15_if_ack);
      prev_en = mem_en;
   endtask

   task automatic tick();
      @(negedge clk);
      mon();
      ack_vec = {l15_if_ack, l1_dm_ack, l1_if_ack, ld_ack, dm_ack, if_ack};
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input string tag, input logic [5:0] mask, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while ((ack_vec & mask) == 6'b0 && n < 40);
      check(tag, 64'((ack_vec & mask) != 6'b0), 64'd1);
   endtask

   initial begin
      int n, k, n_if0, n_dm0;
      ld_req = 0; ld_addr = 0; ld_wdata = 0; if_req = 0; if_addr = 0;
      dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
      l1_if_req = 0; l1_if_addr = 0; l1_dm_req = 0; l1_dm_we = 0; l1_dm_addr = 0;
      l15_if_req = 0; l15_if_addr = 0;
      for (int i = 0; i < 256; i++) begin
         mem_m[i] = 32'h0;
         ref_m[i] = 32'h0;
      end
      mem_m[1] = 32'h2002_0005;
      ref_m[1] = 32'h2002_0005;

      #1 reset = 1'b1;
      #1;
      check("reset_ctl", 64'({mem_en, mem_we, if_ack, dm_ack, ld_ack, busy, owner}), 64'd0);
      check("reset_mem", 64'({mem_addr, mem_wdata}), 64'd0);
      check("reset_rdata", 64'({if_rdata, dm_rdata}), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;

      // single fetch
      push_if(32'h4);
      if_req = 1; if_addr = 32'h4;
      wait_ack("fetch_ack", 6'b000001, n);
      if_req = 0;
      check("fetch_lat", 64'(n - 1), 64'(L + 1));
      check("fetch_data", 64'(if_rdata), 64'h2002_0005);
      check("fetch_clear", 64'({owner, busy}), 64'd0);

      // store then load
      push_dm(1'b1, 32'h40, 32'hDEAD_BEEF);
      dm_req = 1; dm_we = 1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
      wait_ack("store_ack", 6'b000010, n);
      dm_req = 0;
      push_dm(1'b0, 32'h40, 32'h0);
      dm_req = 1; dm_we = 0;
      wait_ack("load_ack", 6'b000010, n);
      dm_req = 0;
      check("load_data", 64'(dm_rdata), 64'hDEAD_BEEF);

      // round-robin contention
      push_if(32'h4); push_dm(1'b0, 32'h40, 32'h0);
      push_if(32'h4); push_dm(1'b0, 32'h40, 32'h0);
      if_req = 1; if_addr = 32'h4; dm_req = 1; dm_we = 0; dm_addr = 32'h40;
      for (int i = 0; i < 4; i++) begin
         wait_ack("rr_ack", 6'b000011, n);
         check("rr_order", 64'(ack_vec[1:0]), (i % 2 == 0) ? 64'd1 : 64'd2);
         if (i == 0) check("rr_first_lat", 64'(n - 1), 64'(L + 1));
         else check("rr_gap", 64'(n), 64'(L + 2));
      end
      if_req = 0; dm_req = 0;
      check("rr_drained", 64'(exp_q.size()), 64'd0);

      // loader priority and starvation of if/dm
      for (int i = 0; i < 8; i++) push_ld(32'h100 + 32'(4 * i), 32'hA5A5_0000 + 32'(i));
      push_if(32'h100);
      push_dm(1'b0, 32'h40, 32'h0);
      n_if0 = n_if_ack; n_dm0 = n_dm_ack;
      ld_req = 1; ld_addr = 32'h100; ld_wdata = 32'hA5A5_0000;
      if_req = 1; if_addr = 32'h100; dm_req = 1; dm_we = 0; dm_addr = 32'h40;
      for (int i = 0; i < 8; i++) begin
         wait_ack("ld_ack", 6'b000100, n);
         if (i == 0) check("ld_first_lat", 64'(n - 1), 64'(L + 1));
         if (i < 7) begin
            ld_addr  = 32'h100 + 32'(4 * (i + 1));
            ld_wdata = 32'hA5A5_0000 + 32'(i + 1);
         end else begin
            ld_req = 0;
         end
      end
      check("ld_starve", 64'({n_if_ack - n_if0, n_dm_ack - n_dm0}), 64'd0);
      wait_ack("post_ld_if", 6'b000001, n);
      if_req = 0;
      check("post_ld_if_data", 64'(if_rdata), 64'hA5A5_0000);
      wait_ack("post_ld_dm", 6'b000010, n);
      dm_req = 0;

      // reset in the second access cycle
      push_if(32'h8);
      if_req = 1; if_addr = 32'h8;
      k = 0;
      while (!prev_en && k < 10) begin
         tick();
         k++;
      end
      check("rst_reached_access", 64'(prev_en), 64'd1);
      n_if0 = n_if_ack;
      reset = 1'b1;
      #1;
      check("rst_mid", 64'({mem_en, mem_we, busy, owner, if_ack}), 64'd0);
      tick();
      reset = 1'b0; if_req = 0;
      repeat (L + 4) tick();
      check("rst_no_ack", 64'(n_if_ack - n_if0), 64'd0);
      check("rst_idle", 64'({owner, busy, mem_en}), 64'd0);
      push_if(32'h4);
      if_req = 1; if_addr = 32'h4;
      wait_ack("rst_fetch", 6'b000001, n);
      if_req = 0;
      check("rst_fetch_lat", 64'(n - 1), 64'(L + 1));

      // LATENCY=1, dm fixed priority
      l1_if_req = 1; l1_if_addr = 32'h10; l1_dm_req = 1; l1_dm_we = 0; l1_dm_addr = 32'h20;
      wait_ack("l1_dm_ack", 6'b010000, n);
      check("l1_dm_first", 64'(ack_vec[4:3]), 64'd2);
      check("l1_dm_lat", 64'(n - 1), 64'd2);
      check("l1_dm_data", 64'(l1_dm_rdata), 64'hFFFF_FFDF);
      l1_dm_req = 0;
      wait_ack("l1_if_ack", 6'b001000, n);
      l1_if_req = 0;
      check("l1_if_gap", 64'(n), 64'd3);
      check("l1_if_data", 64'(l1_if_rdata), 64'hFFFF_FFEF);
      k = n_l1_if;
      l1_if_req = 1; l1_if_addr = 32'h30;
      tick();
      l1_if_req = 0;
      wait_ack("l1_drop_ack", 6'b001000, n);
      check("l1_drop_lat", 64'(n), 64'd2);
      repeat (4) tick();
      check("l1_drop_once", 64'(n_l1_if - k), 64'd1);

      // LATENCY=15, req dropped mid-access
      l15_if_req = 1; l15_if_addr = 32'h44;
      repeat (3) tick();
      l15_if_req = 0;
      wait_ack("l15_ack", 6'b100000, n);
      check("l15_lat", 64'(3 + n - 1), 64'd16);
      check("l15_data", 64'(l15_if_rdata), 64'hFFFF_FFBB);
      repeat (20) tick();
      check("l15_once", 64'(n_l15_if), 64'd1);

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
